// File: rtl/explored_search_engine.sv
// Linear search over the explored-node RAM: membership, record fetch and free-slot lookup.
// Reads issue one address per cycle; compare results come back through an RD_LAT-deep tag pipeline.
module explored_search_engine #(
    parameter int DEPTH   = 255,
    parameter int ADDR_W  = 12,
    parameter int REC_W   = 272,
    parameter int KEY_W   = 16,
    parameter int KEY_LSB = 224,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [KEY_W-1:0]  key,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [REC_W-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic              full,
    output logic [ADDR_W-1:0] hit_addr,
    output logic [REC_W-1:0]  hit_record
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [KEY_W-1:0]    key_q;
    logic [1:0]          mode_q;
    logic                decided;
    logic [RD_LAT-1:0]   vld_pipe;
    logic [ADDR_W-1:0]   tag_pipe [RD_LAT];

    logic [KEY_W-1:0]    rec_key;
    logic [ADDR_W-1:0]   head_tag;
    logic                head_vld;
    logic                is_match;
    logic                is_empty;
    logic                is_last;
    logic                is_slot;
    logic                is_fetch;
    logic                decide;
    logic                issue;

    // Compare side: matching takes priority over empty, so a zero key finds the first empty entry.
    always_comb begin
        rec_key  = rd_data[KEY_LSB +: KEY_W];
        head_tag = tag_pipe[RD_LAT-1];
        head_vld = vld_pipe[RD_LAT-1] && (state == SCAN) && !decided;
        is_match = (rec_key == key_q);
        is_empty = (rec_key == '0);
        is_last  = (head_tag == LAST_C);
        is_slot  = (mode_q == 2'd2);
        is_fetch = (mode_q == 2'd1);
        decide   = head_vld && (is_match || is_empty || is_last);
        issue    = (state == SCAN) && !decided && !decide && (cnt < DEPTH_C);
    end

    assign rd_en   = issue;
    assign rd_addr = issue ? cnt[ADDR_W-1:0] : '0;

    always_ff @(posedge clk) begin
        tag_pipe[0] <= cnt[ADDR_W-1:0];
        for (int i = RD_LAT - 1; i >= 1; i--) begin
            tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // The decision is registered one cycle before DONE so results settle before the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            key_q      <= '0;
            mode_q     <= '0;
            decided    <= 1'b0;
            vld_pipe   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            full       <= 1'b0;
            hit_addr   <= '0;
            hit_record <= '0;
        end else begin
            done <= 1'b0;
            vld_pipe[0] <= issue;
            for (int i = RD_LAT - 1; i >= 1; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state      <= SCAN;
                        key_q      <= key;
                        mode_q     <= mode;
                        cnt        <= '0;
                        decided    <= 1'b0;
                        busy       <= 1'b1;
                        found      <= 1'b0;
                        full       <= 1'b0;
                        hit_addr   <= '0;
                        hit_record <= '0;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state      <= IDLE;
                        vld_pipe   <= '0;
                        decided    <= 1'b0;
                        busy       <= 1'b0;
                        found      <= 1'b0;
                        full       <= 1'b0;
                        hit_addr   <= '0;
                        hit_record <= '0;
                    end else if (decided) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        if (issue) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (decide) begin
                            decided    <= 1'b1;
                            vld_pipe   <= '0;
                            found      <= is_match || (is_empty && is_slot);
                            full       <= !is_match && !is_empty && is_slot;
                            hit_addr   <= head_tag;
                            hit_record <= (is_match && is_fetch) ? rd_data : '0;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    decided  <= 1'b0;
                    vld_pipe <= '0;
                    if (abort) begin
                        found      <= 1'b0;
                        full       <= 1'b0;
                        hit_addr   <= '0;
                        hit_record <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_explored_search_engine.sv
// Directed bench for explored_search_engine: one DUT with RD_LAT=1 and one with RD_LAT=3,
// each behind its own RAM read pipeline over a shared 8-entry record memory.
module tb_explored_search_engine;

    localparam int DEPTH   = 8;
    localparam int ADDR_W  = 4;
    localparam int REC_W   = 272;
    localparam int KEY_W   = 16;
    localparam int KEY_LSB = 224;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              abort = 1'b0;
    logic              start0 = 1'b0;
    logic              start1 = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [KEY_W-1:0]  key = '0;

    logic [ADDR_W-1:0] rd_addr0, rd_addr1, hit_addr0, hit_addr1;
    logic              rd_en0, rd_en1, busy0, busy1, done0, done1;
    logic              found0, found1, full0, full1;
    logic [REC_W-1:0]  rd_data0, rd_data1, hit_record0, hit_record1;

    logic [REC_W-1:0]  mem [DEPTH];
    logic [REC_W-1:0]  pipe1 [3];

    int ecount = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ecount <= ecount + 1;

    always @(posedge clk) rd_data0 <= rd_en0 ? mem[rd_addr0[2:0]] : '0;
    always @(posedge clk) begin
        pipe1[0] <= rd_en1 ? mem[rd_addr1[2:0]] : '0;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign rd_data1 = pipe1[2];

    explored_search_engine #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .REC_W(REC_W), .KEY_W(KEY_W),
                             .KEY_LSB(KEY_LSB), .RD_LAT(1)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort), .mode(mode), .key(key),
        .rd_addr(rd_addr0), .rd_en(rd_en0), .rd_data(rd_data0), .busy(busy0), .done(done0),
        .found(found0), .full(full0), .hit_addr(hit_addr0), .hit_record(hit_record0));

    explored_search_engine #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .REC_W(REC_W), .KEY_W(KEY_W),
                             .KEY_LSB(KEY_LSB), .RD_LAT(3)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort), .mode(mode), .key(key),
        .rd_addr(rd_addr1), .rd_en(rd_en1), .rd_data(rd_data1), .busy(busy1), .done(done1),
        .found(found1), .full(full1), .hit_addr(hit_addr1), .hit_record(hit_record1));

    typedef struct {
        int         sel;
        int         ram;
        logic [1:0] m;
        logic [15:0] k;
        int         extra_at;
        logic [15:0] extra_key;
        logic       e_found;
        logic       e_full;
        int         e_addr;
        int         e_fetch;
        int         e_done;
    } vec_t;

    function automatic logic [REC_W-1:0] mk_rec(input int a, input logic [15:0] k);
        logic [REC_W-1:0] r;
        r = '0;
        r[KEY_LSB +: KEY_W] = k;
        r[15:0]    = 16'hA000 | 16'(a);
        r[271:256] = 16'h5A00 | 16'(a);
        return r;
    endfunction

    task automatic load_ram(input int which);
        logic [15:0] keys_a [DEPTH];
        keys_a = '{16'd5, 16'd9, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = mk_rec(i, (which == 0) ? keys_a[i] : 16'(i + 1));
        end
    endtask

    task automatic check_output(input string name, input logic [REC_W-1:0] act,
                                input logic [REC_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag, input int sel);
        check_output({tag, " rd_addr"},    REC_W'(sel ? rd_addr1 : rd_addr0), '0);
        check_output({tag, " rd_en"},      REC_W'(sel ? rd_en1 : rd_en0), '0);
        check_output({tag, " busy"},       REC_W'(sel ? busy1 : busy0), '0);
        check_output({tag, " done"},       REC_W'(sel ? done1 : done0), '0);
        check_output({tag, " found"},      REC_W'(sel ? found1 : found0), '0);
        check_output({tag, " full"},       REC_W'(sel ? full1 : full0), '0);
        check_output({tag, " hit_addr"},   REC_W'(sel ? hit_addr1 : hit_addr0), '0);
        check_output({tag, " hit_record"}, sel ? hit_record1 : hit_record0, '0);
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        int base, x, done_edge, ndone, max_addr;
        logic first_ok, busy_at_done;
        string nm;
        nm = $sformatf("vec%0d", idx);
        load_ram(v.ram);
        done_edge = -1; ndone = 0; max_addr = -1; first_ok = 1'b0; busy_at_done = 1'b0;
        @(negedge clk);
        mode = v.m;
        key  = v.k;
        if (v.sel == 0) start0 = 1'b1; else start1 = 1'b1;
        base = ecount;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            x = ecount - base - 1;
            if (v.sel ? rd_en1 : rd_en0) begin
                if (int'(v.sel ? rd_addr1 : rd_addr0) > max_addr) max_addr = int'(v.sel ? rd_addr1 : rd_addr0);
                if (x == 0 && (v.sel ? rd_addr1 : rd_addr0) == '0) first_ok = 1'b1;
            end
            if (v.sel ? done1 : done0) begin
                ndone++;
                done_edge = x;
                busy_at_done = v.sel ? busy1 : busy0;
            end
            if (i == v.extra_at) begin
                key = v.extra_key;
                if (v.sel == 0) start0 = 1'b1; else start1 = 1'b1;
            end else begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
        end
        if (ndone == 0) $display("[TB] FAIL %s timeout: no done within 20 cycles", nm);
        check_output({nm, " done_count"},   REC_W'(ndone), REC_W'(1));
        check_output({nm, " done_edge"},    REC_W'(done_edge), REC_W'(v.e_done));
        check_output({nm, " busy_at_done"}, REC_W'(busy_at_done), REC_W'(1));
        check_output({nm, " first_read"},   REC_W'(first_ok), REC_W'(1));
        check_output({nm, " max_addr_ok"},
                     REC_W'(max_addr <= ((v.e_addr + 2 > DEPTH - 1) ? DEPTH - 1 : v.e_addr + 2)), REC_W'(1));
        check_output({nm, " busy_end"},     REC_W'(v.sel ? busy1 : busy0), '0);
        check_output({nm, " found"},        REC_W'(v.sel ? found1 : found0), REC_W'(v.e_found));
        check_output({nm, " full"},         REC_W'(v.sel ? full1 : full0), REC_W'(v.e_full));
        check_output({nm, " hit_addr"},     REC_W'(v.sel ? hit_addr1 : hit_addr0), REC_W'(v.e_addr));
        check_output({nm, " hit_record"},   v.sel ? hit_record1 : hit_record0,
                     (v.e_fetch < 0) ? '0 : mem[v.e_fetch]);
    endtask

    initial begin
        vec_t vecs [14];
        int ndone, nrd;

        //             sel ram mode   key  xat xkey fnd full addr fetch done
        vecs[0]  = '{0, 0, 2'd0, 16'd3,  -1, 0, 1'b1, 1'b0, 2, -1,  5};
        vecs[1]  = '{0, 0, 2'd1, 16'd7,  -1, 0, 1'b0, 1'b0, 3, -1,  6};
        vecs[2]  = '{0, 0, 2'd1, 16'd9,  -1, 0, 1'b1, 1'b0, 1,  1,  4};
        vecs[3]  = '{0, 1, 2'd2, 16'd20, -1, 0, 1'b0, 1'b1, 7, -1, 10};
        vecs[4]  = '{0, 1, 2'd2, 16'd4,  -1, 0, 1'b1, 1'b0, 3, -1,  6};
        vecs[5]  = '{0, 0, 2'd2, 16'd20, -1, 0, 1'b1, 1'b0, 3, -1,  6};
        vecs[6]  = '{0, 0, 2'd0, 16'd0,  -1, 0, 1'b1, 1'b0, 3, -1,  6};
        vecs[7]  = '{0, 1, 2'd0, 16'd20, -1, 0, 1'b0, 1'b0, 7, -1, 10};
        vecs[8]  = '{0, 0, 2'd3, 16'd5,  -1, 0, 1'b1, 1'b0, 0, -1,  3};
        vecs[9]  = '{0, 1, 2'd0, 16'd20,  1, 3, 1'b0, 1'b0, 7, -1, 10};
        vecs[10] = '{1, 1, 2'd0, 16'd7,  -1, 0, 1'b1, 1'b0, 6, -1, 11};
        vecs[11] = '{1, 1, 2'd2, 16'd20, -1, 0, 1'b0, 1'b1, 7, -1, 12};
        vecs[12] = '{1, 0, 2'd1, 16'd0,  -1, 0, 1'b1, 1'b0, 3,  3,  8};
        vecs[13] = '{1, 0, 2'd1, 16'd9,  -1, 0, 1'b1, 1'b0, 1,  1,  6};

        load_ram(0);
        repeat (3) @(negedge clk);
        check_all_zero("reset0", 0);
        check_all_zero("reset1", 1);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) apply_stimulus(vecs[i], i);

        // Abort two cycles into a long scan: no done and cleared outputs.
        load_ram(1);
        @(negedge clk); mode = 2'd0; key = 16'd20; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check_all_zero("abort", 0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        check_output("abort no_done", REC_W'(ndone), '0);

        // Reset mid-scan; dut1 still holds a FETCH hit from the last vector.
        @(negedge clk); mode = 2'd0; key = 16'd20; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check_all_zero("midreset0", 0);
        check_all_zero("midreset1", 1);
        apply_stimulus(vecs[0], 14);

        // start together with abort in IDLE must not begin a search.
        load_ram(0);
        @(negedge clk); mode = 2'd0; key = 16'd3; start0 = 1'b1; abort = 1'b1;
        @(negedge clk); start0 = 1'b0; abort = 1'b0;
        ndone = 0; nrd = 0;
        for (int i = 0; i < 10; i++) begin
            if (done0) ndone++;
            if (rd_en0 || busy0) nrd++;
            @(negedge clk);
        end
        check_output("start_abort no_activity", REC_W'(nrd), '0);
        check_output("start_abort no_done", REC_W'(ndone), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
